// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI burst RAM.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WRITE,
    TURN,
    SEND,
    DROP
  } state_t;

  localparam logic [1:0]  OP_WRITE = 2'b00;
  localparam logic [1:0]  OP_READ  = 2'b01;
  localparam int unsigned CMD_LEN  = 2;
  localparam int unsigned TURN_LEN = 2;

endpackage

// File: rtl/spi_ram_mem.sv
// Single-port RAM with registered read; out-of-range accesses are suppressed (reads return 0).
module spi_ram_mem #(
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_SIZE-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned AW1 = ADDR_SIZE + 1;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                  in_range_c;

  assign in_range_c = {1'b0, addr} < AW1'(MEM_DEPTH);

  // Storage array: contents survive reset.
  always_ff @(posedge clk) begin
    if (we && in_range_c) mem[addr] <= din;
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (re) begin
      dout <= in_range_c ? mem[addr] : '0;
    end
  end

endmodule

// File: rtl/spi_ram_burst.sv
// SPI-slave burst RAM: opcode/address decode, auto-incrementing burst write and prefetching burst read.
// Build option: define SPI_RAM_PARITY_EN to append an even-parity bit to every write word.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic par_err
);

`ifdef SPI_RAM_PARITY_EN
  localparam int unsigned WORD_BITS = DATA_WIDTH + 1;
`else
  localparam int unsigned WORD_BITS = DATA_WIDTH;
`endif
  localparam int unsigned SW      = WORD_BITS - 1;
  localparam int unsigned CNT_MAX = (ADDR_SIZE > WORD_BITS) ? ADDR_SIZE : WORD_BITS;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned AW1     = ADDR_SIZE + 1;

  state_t                state, state_next;
  logic [CW-1:0]         cnt;
  logic [1:0]            op;
  logic [ADDR_SIZE-1:0]  addr;
  logic [SW-1:0]         wshift;
  logic [DATA_WIDTH-1:0] wdata, shreg, dout;
  logic                  commit, commit_wr;

  logic [1:0]            op_full_c;
  logic [WORD_BITS-1:0]  frame_c;
  logic [DATA_WIDTH-1:0] word_c;
  logic                  par_ok_c;
  logic [ADDR_SIZE-1:0]  addr_inc_c;
  logic                  re_c;
  logic                  cmd_last_c, addr_last_c, word_last_c, turn_last_c, bit_last_c;

  // Decode helpers shared by the FSM and the datapath.
  assign op_full_c   = {op[0], MOSI};
  assign frame_c     = {wshift, MOSI};
  assign word_c      = frame_c[WORD_BITS-1 -: DATA_WIDTH];
`ifdef SPI_RAM_PARITY_EN
  assign par_ok_c    = ~^frame_c;
`else
  assign par_ok_c    = 1'b1;
`endif
  assign addr_inc_c  = ({1'b0, addr} == AW1'(MEM_DEPTH - 1)) ? '0 : addr + ADDR_SIZE'(1);
  assign cmd_last_c  = cnt == CW'(CMD_LEN - 1);
  assign addr_last_c = cnt == CW'(ADDR_SIZE - 1);
  assign word_last_c = cnt == CW'(WORD_BITS - 1);
  assign turn_last_c = cnt == CW'(TURN_LEN - 1);
  assign bit_last_c  = cnt == CW'(DATA_WIDTH - 1);
  // Read issued at the first TURN cycle and at the start of every SEND word.
  assign re_c        = ((state == TURN) || (state == SEND)) && (cnt == '0);

  spi_ram_mem #(
    .ADDR_SIZE (ADDR_SIZE),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (commit_wr),
    .re   (re_c),
    .addr (addr),
    .din  (wdata),
    .dout (dout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; deselect always returns to IDLE.
  always_comb begin
    state_next = state;
    if (SS_n) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: state_next = CMD;
        CMD:  if (cmd_last_c)
                state_next = ((op_full_c == OP_WRITE) || (op_full_c == OP_READ)) ? ADDR : DROP;
        ADDR: if (addr_last_c) state_next = (op == OP_WRITE) ? WRITE : TURN;
        TURN: if (turn_last_c) state_next = SEND;
        default: state_next = state;
      endcase
    end
  end

  // Shifters, bit counter, address counter, write commit and parity flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      op        <= '0;
      addr      <= '0;
      wshift    <= '0;
      wdata     <= '0;
      shreg     <= '0;
      commit    <= 1'b0;
      commit_wr <= 1'b0;
      MISO      <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      commit    <= 1'b0;
      commit_wr <= 1'b0;
      MISO      <= 1'b0;
      if (commit) addr <= addr_inc_c;
      if (!SS_n) begin
        unique case (state)
          IDLE: begin
            cnt     <= '0;
            par_err <= 1'b0;
          end
          CMD: begin
            op  <= op_full_c;
            cnt <= cmd_last_c ? '0 : cnt + CW'(1);
          end
          ADDR: begin
            addr <= {addr[ADDR_SIZE-2:0], MOSI};
            cnt  <= addr_last_c ? '0 : cnt + CW'(1);
          end
          WRITE: begin
            wshift <= {wshift[SW-2:0], MOSI};
            if (word_last_c) begin
              cnt       <= '0;
              commit    <= 1'b1;
              commit_wr <= par_ok_c;
              wdata     <= word_c;
              if (!par_ok_c) par_err <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          TURN: begin
            if (turn_last_c) begin
              cnt   <= '0;
              shreg <= dout;
              addr  <= addr_inc_c;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          SEND: begin
            MISO <= shreg[DATA_WIDTH-1];
            if (bit_last_c) begin
              cnt   <= '0;
              shreg <= dout;
              addr  <= addr_inc_c;
            end else begin
              cnt   <= cnt + CW'(1);
              shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
